// File: rtl/sparse_entry_unpacker.sv
// sparse_entry_unpacker: reads a burst of 136-bit entries from the entry memory
// and unpacks each one into a valid/ready stream of (column, value) elements.
// Ports:
//   clk, resetn                 clock, async active-low reset
//   start, num_entries          burst command (sampled in IDLE only)
//   mem_ren, mem_data           one-cycle read pulse; registered read word
//   elem_valid, elem_ready      element handshake
//   elem_col, elem_val          current element payload
//   elem_last                   element closes a matrix row
//   busy, done, hdr_err         status: active, completion pulse, sticky bad header
module sparse_entry_unpacker #(
    parameter int DEPTH = 64,
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [6:0]   num_entries,
    output logic         mem_ren,
    input  logic [135:0] mem_data,
    output logic         elem_valid,
    input  logic         elem_ready,
    output logic [15:0]  elem_col,
    output logic [15:0]  elem_val,
    output logic         elem_last,
    output logic         busy,
    output logic         done,
    output logic         hdr_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [6:0] MAX_ENTRIES = 7'(DEPTH);
    localparam logic [2:0] MAX_LANES   = 3'(LANES);

    state_t       state_q;
    state_t       state_d;
    logic [6:0]   remaining_q;
    logic [127:0] lanes_q;
    logic         row_end_q;
    logic [2:0]   count_q;
    logic [1:0]   lane_q;
    logic         hdr_err_q;

    logic [2:0]   hdr_count;
    logic         hdr_bad;
    logic [2:0]   count_clamped;
    logic [6:0]   start_entries;
    logic         last_lane;
    logic [31:0]  lane_word;
    logic         fire;
    logic         reserved_unused;

    assign hdr_count       = mem_data[134:132];
    assign hdr_bad         = hdr_count > MAX_LANES;
    assign count_clamped   = hdr_bad ? MAX_LANES : hdr_count;
    assign start_entries   = (num_entries > MAX_ENTRIES) ? MAX_ENTRIES
                                                         : num_entries;
    assign last_lane       = ({1'b0, lane_q} == count_q - 3'd1);
    assign lane_word       = lanes_q[{lane_q, 5'd0} +: 32];
    assign fire            = (state_q == S_EMIT) && elem_ready;
    // Header bits [131:128] carry no meaning for this block.
    assign reserved_unused = ^mem_data[131:128];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (num_entries == 7'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Empty entry: skip straight to the next fetch (or finish).
                if (count_clamped == 3'd0) begin
                    state_d = (remaining_q > 7'd1) ? S_FETCH : S_DONE;
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (fire && last_lane) begin
                    state_d = (remaining_q != 7'd0) ? S_FETCH : S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            remaining_q <= '0;
            lanes_q     <= '0;
            row_end_q   <= 1'b0;
            count_q     <= '0;
            lane_q      <= '0;
            hdr_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        remaining_q <= start_entries;
                        hdr_err_q   <= 1'b0;
                    end
                end
                S_WAIT: begin
                    lanes_q   <= mem_data[127:0];
                    row_end_q <= mem_data[135];
                    count_q   <= count_clamped;
                    lane_q    <= '0;
                    if (remaining_q != 7'd0) begin
                        remaining_q <= remaining_q - 7'd1;
                    end
                    if (hdr_bad) begin
                        hdr_err_q <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (fire && !last_lane) begin
                        lane_q <= lane_q + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_ren    = (state_q == S_FETCH);
    assign elem_valid = (state_q == S_EMIT);
    assign elem_col   = elem_valid ? lane_word[31:16] : 16'd0;
    assign elem_val   = elem_valid ? lane_word[15:0] : 16'd0;
    assign elem_last  = elem_valid && row_end_q && last_lane;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign hdr_err    = hdr_err_q;

endmodule

// File: tb/tb_sparse_entry_unpacker.sv
// tb_sparse_entry_unpacker: directed vectors for sparse_entry_unpacker with a
// registered-read memory model and a handshake monitor.
module tb_sparse_entry_unpacker;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [6:0]   num_entries;
    logic         mem_ren;
    logic [135:0] mem_data = '0;
    logic         elem_valid;
    logic         elem_ready;
    logic [15:0]  elem_col;
    logic [15:0]  elem_val;
    logic         elem_last;
    logic         busy;
    logic         done;
    logic         hdr_err;

    always #5 clk = ~clk;

    sparse_entry_unpacker #(.DEPTH(64), .LANES(4)) dut (
        .clk(clk),
        .resetn(resetn),
        .start(start),
        .num_entries(num_entries),
        .mem_ren(mem_ren),
        .mem_data(mem_data),
        .elem_valid(elem_valid),
        .elem_ready(elem_ready),
        .elem_col(elem_col),
        .elem_val(elem_val),
        .elem_last(elem_last),
        .busy(busy),
        .done(done),
        .hdr_err(hdr_err)
    );

    logic [135:0] mem [64];
    logic [5:0]   maddr = '0;

    always @(posedge clk) begin
        if (start) begin
            maddr <= '0;
        end else if (mem_ren) begin
            mem_data <= mem[maddr];
            maddr    <= maddr + 6'd1;
        end
    end

    logic [32:0] got_q[$];
    int ren_cnt  = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (resetn && elem_valid && elem_ready)
            got_q.push_back({elem_last, elem_col, elem_val});
        if (mem_ren) ren_cnt++;
        if (done) done_cnt++;
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [135:0] mk(input logic re, input logic [2:0] cnt,
                                        input logic [31:0] l0, input logic [31:0] l1,
                                        input logic [31:0] l2, input logic [31:0] l3);
        return {re, cnt, 4'hA, l3, l2, l1, l0};
    endfunction

    typedef struct {
        string        name;
        logic [6:0]   n;
        logic [135:0] ent[3];
        logic [15:0]  rdy;
        int           exp_cyc;
        int           exp_ren;
        int           exp_n;
        logic [32:0]  exp_el[8];
        logic         exp_err;
    } vec_t;

    vec_t vt[6];

    task automatic run_vec(input vec_t v);
        int cyc;
        logic [33:0] prev;
        logic prev_hold;
        for (int i = 0; i < 3; i++) mem[i] = v.ent[i];
        got_q.delete();
        ren_cnt  = 0;
        done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1;
        num_entries = v.n;
        elem_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        chk({v.name, " busy"}, 64'(busy), 64'd1);
        prev = '0;
        prev_hold = 1'b0;
        while (!done && cyc < 300) begin
            elem_ready = (cyc < 16) ? v.rdy[cyc] : 1'b1;
            if (prev_hold)
                chk({v.name, " hold"},
                    64'({elem_valid, elem_last, elem_col, elem_val}), 64'(prev));
            prev_hold = elem_valid && !elem_ready;
            prev = {elem_valid, elem_last, elem_col, elem_val};
            @(posedge clk); #1;
            cyc++;
        end
        chk({v.name, " done"}, 64'(done), 64'd1);
        chk({v.name, " cycles"}, 64'(cyc), 64'(v.exp_cyc));
        chk({v.name, " mem_ren"}, 64'(ren_cnt), 64'(v.exp_ren));
        chk({v.name, " elems"}, 64'(got_q.size()), 64'(v.exp_n));
        for (int i = 0; i < v.exp_n && i < got_q.size(); i++)
            chk($sformatf("%s el%0d", v.name, i), 64'(got_q[i]), 64'(v.exp_el[i]));
        chk({v.name, " hdr_err"}, 64'(hdr_err), 64'(v.exp_err));
        elem_ready = 1'b1;
        @(posedge clk); #1;
        chk({v.name, " idle"}, 64'({busy, done}), 64'd0);
        chk({v.name, " done once"}, 64'(done_cnt), 64'd1);
    endtask

    initial begin
        int cyc;
        resetn = 1'b0;
        start = 1'b0;
        num_entries = '0;
        elem_ready = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[63] = mk(1'b1, 3'd1, {16'h0063, 16'h6363}, 32'h0, 32'h0, 32'h0);

        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 8; j++) vt[i].exp_el[j] = '0;
            for (int j = 0; j < 3; j++) vt[i].ent[j] = '0;
            vt[i].rdy = 16'hFFFF;
            vt[i].exp_err = 1'b0;
        end

        vt[0].name = "single";
        vt[0].n = 7'd1;
        vt[0].ent[0] = mk(1'b1, 3'd3, {16'd2, 16'h0011}, {16'd5, 16'h0022},
                          {16'd9, 16'h0033}, 32'hFFFF_FFFF);
        vt[0].exp_cyc = 6;
        vt[0].exp_ren = 1;
        vt[0].exp_n = 3;
        vt[0].exp_el[0] = {1'b0, 16'd2, 16'h0011};
        vt[0].exp_el[1] = {1'b0, 16'd5, 16'h0022};
        vt[0].exp_el[2] = {1'b1, 16'd9, 16'h0033};

        vt[1] = vt[0];
        vt[1].name = "backpressure";
        vt[1].rdy = 16'hFFCF;
        vt[1].exp_cyc = 8;

        vt[2].name = "burst";
        vt[2].n = 7'd3;
        vt[2].ent[0] = mk(1'b0, 3'd4, {16'h0001, 16'h0101}, {16'h0003, 16'h0303},
                          {16'h0004, 16'h0404}, {16'h0007, 16'h0707});
        vt[2].ent[1] = mk(1'b0, 3'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                          32'hDEAD_BEEF, 32'hDEAD_BEEF);
        vt[2].ent[2] = mk(1'b1, 3'd2, {16'h000A, 16'hAAAA}, {16'h000C, 16'hCCCC},
                          32'hFFFF_FFFF, 32'hFFFF_FFFF);
        vt[2].exp_cyc = 13;
        vt[2].exp_ren = 3;
        vt[2].exp_n = 6;
        vt[2].exp_el[0] = {1'b0, 16'h0001, 16'h0101};
        vt[2].exp_el[1] = {1'b0, 16'h0003, 16'h0303};
        vt[2].exp_el[2] = {1'b0, 16'h0004, 16'h0404};
        vt[2].exp_el[3] = {1'b0, 16'h0007, 16'h0707};
        vt[2].exp_el[4] = {1'b0, 16'h000A, 16'hAAAA};
        vt[2].exp_el[5] = {1'b1, 16'h000C, 16'hCCCC};

        vt[3].name = "hdr6";
        vt[3].n = 7'd1;
        vt[3].ent[0] = mk(1'b1, 3'd6, {16'd20, 16'h1000}, {16'd21, 16'h2000},
                          {16'd22, 16'h3000}, {16'd23, 16'h4000});
        vt[3].exp_cyc = 7;
        vt[3].exp_ren = 1;
        vt[3].exp_n = 4;
        vt[3].exp_el[0] = {1'b0, 16'd20, 16'h1000};
        vt[3].exp_el[1] = {1'b0, 16'd21, 16'h2000};
        vt[3].exp_el[2] = {1'b0, 16'd22, 16'h3000};
        vt[3].exp_el[3] = {1'b1, 16'd23, 16'h4000};
        vt[3].exp_err = 1'b1;

        vt[4].name = "zero";
        vt[4].n = 7'd0;
        vt[4].exp_cyc = 1;
        vt[4].exp_ren = 0;
        vt[4].exp_n = 0;

        vt[5].name = "saturate";
        vt[5].n = 7'd100;
        vt[5].exp_cyc = 130;
        vt[5].exp_ren = 64;
        vt[5].exp_n = 1;
        vt[5].exp_el[0] = {1'b1, 16'h0063, 16'h6363};

        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs",
            64'({mem_ren, elem_valid, elem_last, busy, done, hdr_err,
                 elem_col, elem_val}), 64'd0);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("idle after reset", 64'({busy, mem_ren, done}), 64'd0);

        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        mem[0] = vt[0].ent[0];
        got_q.delete();
        ren_cnt = 0;
        done_cnt = 0;
        elem_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        num_entries = 7'd1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        repeat (2) begin
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b1;
        num_entries = 7'd5;
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
        while (!done && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("busy start cycles", 64'(cyc), 64'd6);
        chk("busy start elems", 64'(got_q.size()), 64'd3);
        repeat (4) @(posedge clk);
        #1;
        chk("busy start idle", 64'(busy), 64'd0);
        chk("busy start mem_ren", 64'(ren_cnt), 64'd1);
        chk("busy start done", 64'(done_cnt), 64'd1);

        mem[0] = vt[3].ent[0];
        @(posedge clk); #1;
        start = 1'b1;
        num_entries = 7'd1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("lane1 before reset", 64'({elem_valid, elem_col, hdr_err}),
            64'({1'b1, 16'd21, 1'b1}));
        resetn = 1'b0;
        #1;
        chk("mid-burst reset",
            64'({mem_ren, elem_valid, elem_last, busy, done, hdr_err,
                 elem_col, elem_val}), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("idle after mid reset", 64'({busy, done, elem_valid}), 64'd0);
        run_vec(vt[0]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
